// File: rtl/period_meter.sv
//==============================================================================
// Module   : period_meter
// Purpose  : Measures the half-period of a slow square wave against CLK_50M.
//            Counts CLK_50M cycles between consecutive sig_in edges (either
//            polarity) and reports that count minus one. This is the value a
//            toggle-output divider needs on its count_to input to produce the
//            observed waveform.
// Ports    : CLK_50M   in   1  system clock (50 MHz)
//            reset     in   1  synchronous, active-high reset
//            enable    in   1  measurement enable, low forces IDLE
//            sig_in    in   1  asynchronous square wave to measure
//            count_out out 32  last measured half-period minus 1
//            valid     out  1  one-cycle pulse when count_out updates
//            locked    out  1  high while the last two measurements match
//            timeout   out  1  sticky: no edge within TIMEOUT cycles
// Revision : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module period_meter #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] TIMEOUT     = 32'd50_000_000
) (
    input  logic        CLK_50M,
    input  logic        reset,
    input  logic        enable,
    input  logic        sig_in,
    output logic [31:0] count_out,
    output logic        valid,
    output logic        locked,
    output logic        timeout
);

    // A single flop cannot resolve metastability, so depth is clamped at 2.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    // Last count value reachable before a timeout is declared; the counter
    // never goes past it, so it cannot wrap.
    localparam logic [31:0] CNT_LAST = TIMEOUT - 32'd1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SYNC_N-1:0] sync_q, sync_d;
    logic          sig_d_q, sig_d_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   prev_meas_q, prev_meas_d;
    logic          have_meas_q, have_meas_d;
    logic [31:0]   count_out_q, count_out_d;
    logic          valid_q, valid_d;
    logic          locked_q, locked_d;
    logic          timeout_q, timeout_d;

    logic          sig_s;
    logic          sig_edge;
    logic          at_limit;

    //--------------------------------------------------------------------------
    // Input conditioning: runs in every state so that sig_d always tracks
    // sig_s and no stale level produces a false edge on re-enable.
    //--------------------------------------------------------------------------
    always_comb begin
        sync_d   = {sync_q[SYNC_N-2:0], sig_in};
        sig_s    = sync_q[SYNC_N-1];
        sig_d_d  = sig_s;
        sig_edge = sig_s ^ sig_d_q;
        at_limit = (cnt_q == CNT_LAST);
    end

    //--------------------------------------------------------------------------
    // Next-state and datapath
    //--------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prev_meas_d = prev_meas_q;
        have_meas_d = have_meas_q;
        count_out_d = count_out_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        timeout_d   = timeout_q;

        if (!enable) begin
            // Any in-flight interval is dropped; count_out keeps its value.
            state_d     = ST_IDLE;
            cnt_d       = 32'd0;
            have_meas_d = 1'b0;
            locked_d    = 1'b0;
            timeout_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d       = 32'd0;
                    have_meas_d = 1'b0;
                    locked_d    = 1'b0;
                    timeout_d   = 1'b0;
                    state_d     = ST_ARM;
                end

                ST_ARM: begin
                    // First edge only starts the interval; nothing is reported.
                    if (sig_edge) begin
                        cnt_d   = 32'd0;
                        state_d = ST_MEASURE;
                    end else if (at_limit) begin
                        timeout_d   = 1'b1;
                        locked_d    = 1'b0;
                        count_out_d = 32'd0;
                        cnt_d       = 32'd0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end

                ST_MEASURE: begin
                    // An edge on the threshold cycle still counts as a
                    // measurement, hence the edge test comes first.
                    if (sig_edge) begin
                        count_out_d = cnt_q;
                        valid_d     = 1'b1;
                        prev_meas_d = cnt_q;
                        locked_d    = have_meas_q && (cnt_q == prev_meas_q);
                        have_meas_d = 1'b1;
                        timeout_d   = 1'b0;
                        cnt_d       = 32'd0;
                    end else if (at_limit) begin
                        timeout_d   = 1'b1;
                        locked_d    = 1'b0;
                        count_out_d = 32'd0;
                        have_meas_d = 1'b0;
                        cnt_d       = 32'd0;
                        state_d     = ST_ARM;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 32'd0;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // State registers
    //--------------------------------------------------------------------------
    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sync_q      <= '0;
            sig_d_q     <= 1'b0;
            cnt_q       <= 32'd0;
            prev_meas_q <= 32'd0;
            have_meas_q <= 1'b0;
            count_out_q <= 32'd0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            sig_d_q     <= sig_d_d;
            cnt_q       <= cnt_d;
            prev_meas_q <= prev_meas_d;
            have_meas_q <= have_meas_d;
            count_out_q <= count_out_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
        end
    end

    assign count_out = count_out_q;
    assign valid     = valid_q;
    assign locked    = locked_q;
    assign timeout   = timeout_q;

endmodule

`default_nettype wire
